// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - writeback, read and issue-scoreboard signals of reg_file_sb
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();
    localparam int NREG = 1 << ADDR_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              iss_valid;
    logic [ADDR_W-1:0] iss_dest;
    logic              iss_wr;
    logic              iss_use1;
    logic              iss_use2;
    logic              iss_stall;
    logic [NREG-1:0]   busy_vec;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
               iss_valid, iss_dest, iss_wr, iss_use1, iss_use2,
        input  rd_data1, rd_data2, iss_stall, busy_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
               iss_valid, iss_dest, iss_wr, iss_use1, iss_use2,
        output rd_data1, rd_data2, iss_stall, busy_vec
    );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - two-read/one-write register file with issue scoreboard and bypass
module reg_file_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    reg_file_sb_if.slave   bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam bit Z0   = (ZERO_R0 != 0);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_eff;
    logic [NREG-1:0]   wr_mask;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   busy_nxt;
    logic              wr_ok;
    logic              bypass;
    logic              stall;
    logic              accept;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    // A write to r0 is dropped entirely when r0 is hardwired to zero.
    assign wr_ok  = bus.wr_en && !(Z0 && bus.wr_addr == '0);
    assign bypass = wr_ok && rst_n;

    always_comb begin
        rd1 = regs[bus.rd_addr1];
        rd2 = regs[bus.rd_addr2];
        if (bypass && bus.rd_addr1 == bus.wr_addr) rd1 = bus.wr_data;
        if (bypass && bus.rd_addr2 == bus.wr_addr) rd2 = bus.wr_data;
        if (Z0 && bus.rd_addr1 == '0) rd1 = '0;
        if (Z0 && bus.rd_addr2 == '0) rd2 = '0;
    end

    // A register being written back this cycle is treated as ready: its data reaches the reader by bypass.
    always_comb begin
        wr_mask  = wr_ok ? (NREG'(1) << bus.wr_addr) : '0;
        busy_eff = busy & ~wr_mask;
        stall    = bus.iss_valid &&
                   ((bus.iss_use1 && busy_eff[bus.rd_addr1]) ||
                    (bus.iss_use2 && busy_eff[bus.rd_addr2]) ||
                    (bus.iss_wr   && busy_eff[bus.iss_dest]));
        accept   = bus.iss_valid && !stall;
        set_mask = (accept && bus.iss_wr && !(Z0 && bus.iss_dest == '0))
                   ? (NREG'(1) << bus.iss_dest) : '0;
        // Set after clear so a new owner issued alongside the old writeback stays pending.
        busy_nxt = (busy & ~wr_mask) | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            busy <= busy_nxt;
            if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.rd_data1  = rd1;
    assign bus.rd_data2  = rd2;
    assign bus.iss_stall = stall;
    assign bus.busy_vec  = busy;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed bench for reg_file_sb, r0-zero (u0) and plain-r0 (u1) copies side by side
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) b0 ();
    reg_file_sb_if #(.DATA_W(16), .ADDR_W(3)) b1 ();

    assign b1.wr_en     = b0.wr_en;
    assign b1.wr_addr   = b0.wr_addr;
    assign b1.wr_data   = b0.wr_data;
    assign b1.rd_addr1  = b0.rd_addr1;
    assign b1.rd_addr2  = b0.rd_addr2;
    assign b1.iss_valid = b0.iss_valid;
    assign b1.iss_dest  = b0.iss_dest;
    assign b1.iss_wr    = b0.iss_wr;
    assign b1.iss_use1  = b0.iss_use1;
    assign b1.iss_use2  = b0.iss_use2;

    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        b0.wr_en = 1'b0; b0.wr_addr = '0; b0.wr_data = '0;
        b0.rd_addr1 = '0; b0.rd_addr2 = '0;
        b0.iss_valid = 1'b0; b0.iss_dest = '0; b0.iss_wr = 1'b0;
        b0.iss_use1 = 1'b0; b0.iss_use2 = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        b0.rd_addr1 = 3'd5; b0.iss_use1 = 1'b1; b0.iss_wr = 1'b1;
        #1;
        chk("reset_rd1", b0.rd_data1, 16'h0);
        chk("reset_busy0", b0.busy_vec, 8'h00);
        chk("reset_busy1", b1.busy_vec, 8'h00);
        chk("idle_no_stall", b0.iss_stall, 1'b0);

        // Same-cycle bypass, then stored value
        @(negedge clk); idle();
        b0.wr_en = 1'b1; b0.wr_addr = 3'd3; b0.wr_data = 16'hBEEF; b0.rd_addr1 = 3'd3;
        #1 chk("bypass_beef", b0.rd_data1, 16'hBEEF);
        step();
        @(negedge clk); b0.wr_en = 1'b0;
        #1 chk("stored_beef", b0.rd_data1, 16'hBEEF);

        // Write to r0
        @(negedge clk); idle();
        b0.wr_en = 1'b1; b0.wr_addr = 3'd0; b0.wr_data = 16'h1234; b0.rd_addr1 = 3'd0; b0.rd_addr2 = 3'd0;
        #1;
        chk("r0_bypass_z", b0.rd_data1, 16'h0);
        chk("r0_bypass_nz", b1.rd_data2, 16'h1234);
        step();
        @(negedge clk); b0.wr_en = 1'b0;
        #1;
        chk("r0_stored_z", b0.rd_data1, 16'h0);
        chk("r0_stored_nz", b1.rd_data1, 16'h1234);
        chk("r0_busy_z", b0.busy_vec, 8'h00);

        // RAW on r4: stall, then resolved by a same-cycle writeback
        @(negedge clk); idle();
        b0.iss_valid = 1'b1; b0.iss_wr = 1'b1; b0.iss_dest = 3'd4;
        #1 chk("iss4_accept", b0.iss_stall, 1'b0);
        step();
        chk("busy4_set", b0.busy_vec, 8'h10);
        @(negedge clk); idle();
        b0.iss_valid = 1'b1; b0.iss_use1 = 1'b1; b0.rd_addr1 = 3'd4;
        #1 chk("raw4_stall", b0.iss_stall, 1'b1);
        b0.wr_en = 1'b1; b0.wr_addr = 3'd4; b0.wr_data = 16'h4444;
        #1;
        chk("raw4_resolved", b0.iss_stall, 1'b0);
        chk("raw4_bypass", b0.rd_data1, 16'h4444);
        step();
        chk("busy4_cleared", b0.busy_vec, 8'h00);

        // WAW on r2, also RAW via port 2
        @(negedge clk); idle();
        b0.iss_valid = 1'b1; b0.iss_wr = 1'b1; b0.iss_dest = 3'd2;
        step();
        chk("busy2_set", b1.busy_vec, 8'h04);
        @(negedge clk);
        #1 chk("waw2_stall", b0.iss_stall, 1'b1);
        b0.iss_wr = 1'b0; b0.iss_use2 = 1'b1; b0.rd_addr2 = 3'd2;
        #1 chk("raw2_port2_stall", b0.iss_stall, 1'b1);
        b0.iss_wr = 1'b1; b0.iss_use2 = 1'b0;
        step();
        chk("busy2_after_stall", b0.busy_vec, 8'h04);
        @(negedge clk);
        b0.wr_en = 1'b1; b0.wr_addr = 3'd2; b0.wr_data = 16'h2222;
        #1 chk("waw2_resolved", b0.iss_stall, 1'b0);
        step();
        chk("busy2_set_wins", b0.busy_vec, 8'h04);

        // Writeback to non-busy r6
        @(negedge clk); idle();
        b0.wr_en = 1'b1; b0.wr_addr = 3'd6; b0.wr_data = 16'h6666;
        step();
        @(negedge clk); idle(); b0.rd_addr1 = 3'd6; b0.rd_addr2 = 3'd2;
        #1;
        chk("wb6_busy", b0.busy_vec, 8'h04);
        chk("wb6_data", b0.rd_data1, 16'h6666);
        chk("r2_data", b0.rd_data2, 16'h2222);

        // Issue to r0
        @(negedge clk); idle();
        b0.iss_valid = 1'b1; b0.iss_wr = 1'b1; b0.iss_dest = 3'd0;
        step();
        chk("iss0_busy_z", b0.busy_vec, 8'h04);
        chk("iss0_busy_nz", b1.busy_vec, 8'h05);

        // Claim every register with a coincident writeback
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); idle();
            b0.iss_valid = 1'b1; b0.iss_wr = 1'b1; b0.iss_dest = 3'(i);
            b0.wr_en = 1'b1; b0.wr_addr = 3'(i); b0.wr_data = 16'((i + 1) * 16'h1111);
            #1 chk($sformatf("fill%0d_stall", i), b1.iss_stall, 1'b0);
            step();
        end
        chk("fill_busy_z", b0.busy_vec, 8'hFE);
        chk("fill_busy_nz", b1.busy_vec, 8'hFF);
        @(negedge clk); idle(); b0.rd_addr1 = 3'd7; b0.rd_addr2 = 3'd0;
        #1;
        chk("fill_r7", b1.rd_data1, 16'h8888);
        chk("fill_r0_nz", b1.rd_data2, 16'h1111);
        chk("fill_r0_z", b0.rd_data2, 16'h0);

        // Asynchronous reset between edges, with a write in flight
        @(negedge clk);
        b0.wr_en = 1'b1; b0.wr_addr = 3'd3; b0.wr_data = 16'hABCD; b0.rd_addr1 = 3'd3; b0.rd_addr2 = 3'd5;
        #1 chk("pre_rst_bypass", b1.rd_data1, 16'hABCD);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy_nz", b1.busy_vec, 8'h00);
        chk("rst_busy_z", b0.busy_vec, 8'h00);
        chk("rst_rd1_nobypass", b1.rd_data1, 16'h0);
        chk("rst_rd2", b1.rd_data2, 16'h0);
        @(posedge clk); #1;
        chk("rst_hold_rd1", b1.rd_data1, 16'h0);
        @(negedge clk); idle(); rst_n = 1'b1;
        b0.rd_addr1 = 3'd7;
        #1 chk("post_rst_r7", b1.rd_data1, 16'h0);

        // Operation resumes after reset release
        @(negedge clk);
        b0.wr_en = 1'b1; b0.wr_addr = 3'd7; b0.wr_data = 16'h7777;
        step();
        @(negedge clk); b0.wr_en = 1'b0;
        #1 chk("post_rst_write", b1.rd_data1, 16'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 3: register address width; depth NREG = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_R0, default 1: 1 makes register 0 read-only zero; 0 makes it an ordinary register.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port wr_en  input  1  writeback strobe.
REQ-007 SHALL have port wr_addr  input  ADDR_W  writeback destination.
REQ-008 SHALL have port wr_data  input  DATA_W  writeback data.
REQ-009 SHALL have port rd_addr1 / rd_addr2  input  ADDR_W each  read addresses.
REQ-010 SHALL have port rd_data1 / rd_data2  output  DATA_W each  read data, combinational.
REQ-011 SHALL have port iss_valid  input  1  an instruction requests issue this cycle.
REQ-012 SHALL have port iss_dest  input  ADDR_W  destination of issuing instruction.
REQ-013 SHALL have port iss_wr  input  1  issuing instruction writes iss_dest.
REQ-014 SHALL have port iss_use1 / iss_use2  input  1 each  issuing instruction reads rd_addr1 / rd_addr2.
REQ-015 SHALL have port iss_stall  output  1  issue blocked this cycle, combinational.
REQ-016 SHALL have port busy_vec  output  NREG  per-register pending-write bits, registered.

Function
REQ-017 SHALL store NREG registers of DATA_W bits.
REQ-018 SHALL write wr_data into register wr_addr on a rising clk edge when wr_en=1, unless wr_addr=0 and ZERO_R0=1 (write dropped).
REQ-019 SHALL drive rd_dataN = wr_data when wr_en=1, rd_addrN=wr_addr, and the write is not dropped (same-cycle bypass); otherwise the stored value.
REQ-020 SHALL return 0 on rd_dataN for rd_addrN=0 when ZERO_R0=1, regardless of wr_en.
REQ-021 SHALL define an issue as accepted when iss_valid=1 and iss_stall=0.
REQ-022 SHALL assert iss_stall when iss_valid=1 and any of: iss_use1 with busy[rd_addr1]; iss_use2 with busy[rd_addr2]; iss_wr with busy[iss_dest] (WAW).
REQ-023 SHALL ignore a busy bit in REQ-022 when the same cycle carries a non-dropped writeback to that register (data is bypassed, hazard resolved).
REQ-024 SHALL hold iss_stall=0 when iss_valid=0.
REQ-025 SHALL set busy[iss_dest] on the clock edge of an accepted issue with iss_wr=1, except dest 0 when ZERO_R0=1.
REQ-026 SHALL clear busy[wr_addr] on the clock edge of a non-dropped writeback.
REQ-027 SHALL, when an accepted issue and a writeback target the same register in one cycle, leave busy set (set wins; new owner pending).
REQ-028 SHALL ignore writeback to a non-busy register for scoreboard purposes (data still written, busy stays 0).
REQ-029 SHALL keep busy[0]=0 at all times when ZERO_R0=1.
REQ-030 SHALL add no latency: issue decision, bypass and reads resolve in the same cycle; state visible the cycle after the edge.

Reset
REQ-031 SHALL, while rst_n=0, immediately and asynchronously clear all registers to 0 and busy_vec to 0, independent of clk.
REQ-032 SHALL ignore wr_en and accepted issues while rst_n=0; rd_dataN read 0 except bypassed wr_data is not permitted during reset (outputs 0).
REQ-033 SHALL discard pending writes and issues on reset asserted mid-operation; first operation after rst_n rises takes effect on the next rising clk.

Verification
REQ-034 SHALL cover: reset, then rd_addr1=5 -> rd_data1=0, busy_vec=0, iss_stall=0.
REQ-035 SHALL cover: wr_en=1, wr_addr=3, wr_data=16'hBEEF, rd_addr1=3 same cycle -> rd_data1=16'hBEEF; next cycle stored 16'hBEEF.
REQ-036 SHALL cover: write 16'h1234 to addr 0 with ZERO_R0=1 -> rd_data=0, busy[0]=0; with ZERO_R0=0 -> reads 16'h1234.
REQ-037 SHALL cover: issue iss_wr=1 dest=4 -> busy[4]=1; next cycle iss_use1=1 rd_addr1=4 -> iss_stall=1; same with wr_en to 4 -> iss_stall=0, rd_data1=wr_data, busy[4] cleared unless new issue sets it.
REQ-038 SHALL cover: busy[2]=1, issue iss_wr=1 dest=2 with no writeback -> iss_stall=1 (WAW); with writeback to 2 same cycle -> accepted, busy[2] stays 1.
REQ-039 SHALL cover: rst_n pulsed low between clk edges with busy_vec=8'hFF and registers non-zero -> busy_vec and all reads 0 before the next edge.
